// File: rtl/dmem_bus_bridge_if.sv
// Data-memory bus between the load/store bridge (master) and the memory slave.
// valid/ready handshake with word-aligned offset addressing and byte enables.
interface dmem_bus_bridge_if;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_ready, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_ready, bus_rdata
  );
endinterface

// File: rtl/dmem_bus_bridge.sv
// MEM-stage load/store bridge: range/alignment check, one bus transaction per
// access with timeout, core stall until completion, extended load data.
module dmem_bus_bridge #(
  parameter logic [31:0] DMEM_BASE_ADDR = 32'h0000_1000,
  parameter logic [31:0] DMEM_SIZE      = 32'h0000_1000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [31:0]       core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [1:0]        core_size,
  input  logic              core_unsigned,
  output logic              core_stall,
  output logic [31:0]       core_rdata,
  output logic              core_fault,
  dmem_bus_bridge_if.master bus
);

  localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:2]   word_q;
  logic [1:0]    lane_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   rdata_q;
  logic          timeout_q;

  logic [31:0] off;
  logic        bad;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {lane, 3'b000});
    h = 16'(w >> {lane[1], 4'b0000});
    case (size)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Decode of the op currently presented by the core (only consumed in IDLE).
  always_comb begin
    off = core_addr - DMEM_BASE_ADDR;
    bad = (core_size == 2'b11) ||
          (core_addr < DMEM_BASE_ADDR) ||
          (off >= DMEM_SIZE) ||
          ((core_size == 2'b01) && core_addr[0]) ||
          ((core_size == 2'b10) && (core_addr[1:0] != 2'b00));
    be_n    = '0;
    wdata_n = core_wdata;
    case (core_size)
      2'b00: begin
        be_n    = 4'b0001 << core_addr[1:0];
        wdata_n = {4{core_wdata[7:0]}};
      end
      2'b01: begin
        be_n    = core_addr[1] ? 4'b1100 : 4'b0011;
        wdata_n = {2{core_wdata[15:0]}};
      end
      default: be_n = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      word_q    <= '0;
      lane_q    <= '0;
      we_q      <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (core_req && !bad) begin
            word_q  <= off[31:2];
            lane_q  <= core_addr[1:0];
            we_q    <= core_we;
            size_q  <= core_size;
            uns_q   <= core_unsigned;
            wdata_q <= wdata_n;
            be_q    <= core_we ? be_n : 4'b0000;
            cnt_q   <= '0;
            state_q <= BUS;
          end
        end
        BUS: begin
          // Acceptance wins over a timeout landing in the same cycle.
          if (bus.bus_ready) begin
            rdata_q <= we_q ? 32'h0 : extract(bus.bus_rdata, lane_q, size_q, uns_q);
            cnt_q   <= '0;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            rdata_q   <= '0;
            cnt_q     <= '0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          timeout_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accept/reject in IDLE is combinational so a rejected op never stalls.
  always_comb begin
    core_stall    = 1'b0;
    core_fault    = 1'b0;
    core_rdata    = '0;
    bus.bus_valid = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_we    = 1'b0;
    bus.bus_be    = '0;
    bus.bus_wdata = '0;
    case (state_q)
      IDLE: begin
        if (rst_n && core_req) begin
          core_fault = bad;
          core_stall = !bad;
        end
      end
      BUS: begin
        core_stall    = 1'b1;
        bus.bus_valid = 1'b1;
        bus.bus_addr  = {word_q, 2'b00};
        bus.bus_we    = we_q;
        bus.bus_be    = be_q;
        bus.bus_wdata = wdata_q;
      end
      DONE: begin
        core_rdata = rdata_q;
        core_fault = timeout_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Bench for dmem_bus_bridge: directed scenarios plus random back-to-back ops,
// checked against a byte-addressed memory model and arithmetic lane rules.
module tb_dmem_bus_bridge;
  localparam int unsigned BASE    = 32'h1000;
  localparam int unsigned SIZE    = 32'h1000;
  localparam int          TIMEOUT = 16;

  logic        clk;
  logic        rst_n;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [1:0]  core_size;
  logic        core_unsigned;
  logic        core_stall;
  logic [31:0] core_rdata;
  logic        core_fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] slave_mem [0:1023];
  logic [7:0]  ref_mem   [0:4095];

  dmem_bus_bridge_if bus_if ();

  dmem_bus_bridge #(
    .DMEM_BASE_ADDR (32'h0000_1000),
    .DMEM_SIZE      (32'h0000_1000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_req      (core_req),
    .core_we       (core_we),
    .core_addr     (core_addr),
    .core_wdata    (core_wdata),
    .core_size     (core_size),
    .core_unsigned (core_unsigned),
    .core_stall    (core_stall),
    .core_rdata    (core_rdata),
    .core_fault    (core_fault),
    .bus           (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit exp_bad(input logic [31:0] addr, input logic [1:0] size);
    longint a = longint'(addr);
    return (size == 2'd3) || (a < BASE) || (a >= BASE + SIZE) ||
           (size == 2'd1 && a % 2 != 0) || (size == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [1:0] size,
                                           input logic uns);
    int unsigned off = addr - BASE;
    int unsigned n = 1 << size;
    longint v = 0;
    for (int unsigned i = 0; i < n; i++) v += longint'(ref_mem[off + i]) << (8 * i);
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] addr, input logic [1:0] size);
    int unsigned n = 1 << size;
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wdata, input logic [1:0] size);
    int unsigned n = 1 << size;
    logic [31:0] r = '0;
    for (int unsigned i = 0; i < 4; i++) r |= ((wdata >> (8 * (i % n))) & 32'hFF) << (8 * i);
    return r;
  endfunction

  task automatic mem_set(input int unsigned widx, input logic [31:0] val);
    slave_mem[widx] = val;
    for (int unsigned k = 0; k < 4; k++) ref_mem[4 * widx + k] = 8'(val >> (8 * k));
  endtask

  // One core op; called just after a negedge, returns just after a negedge.
  // waits < 0 means the slave never asserts bus_ready.
  task automatic run_op(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input int waits);
    bit          bad, done;
    int          stall_n, valid_n, exp_stall, exp_valid;
    logic [31:0] exp_rd, exp_addr;
    logic [3:0]  be_w;
    bad = exp_bad(addr, size);
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
    core_size = size; core_unsigned = uns;
    #1;
    if (bad) begin
      checks++;
      if (core_fault !== 1'b1 || core_stall !== 1'b0 || core_rdata !== 32'h0 ||
          bus_if.bus_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s reject: fault=%b stall=%b rdata=%h valid=%b, want fault=1 stall=0 rdata=0 valid=0",
                 name, core_fault, core_stall, core_rdata, bus_if.bus_valid);
      end
      @(negedge clk); #1;
      checks++;
      if (bus_if.bus_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s no_bus: bus_valid=%b, want 0", name, bus_if.bus_valid);
      end
      @(negedge clk);
      return;
    end
    exp_rd    = (we || waits < 0) ? 32'h0 : exp_load(addr, size, uns);
    exp_addr  = (addr - BASE) & 32'hFFFF_FFFC;
    exp_stall = (waits < 0) ? TIMEOUT + 1 : waits + 2;
    exp_valid = (waits < 0) ? TIMEOUT : waits + 1;
    stall_n = 0; valid_n = 0; done = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) #1;
      if (core_stall === 1'b1) begin
        stall_n++;
        if (bus_if.bus_valid === 1'b1) begin
          checks++;
          if (bus_if.bus_addr !== exp_addr || bus_if.bus_we !== we ||
              bus_if.bus_be !== (we ? exp_be(addr, size) : 4'b0000) ||
              (we && bus_if.bus_wdata !== exp_wdata(wdata, size))) begin
            errors++;
            $display("FAIL %s bus: addr=%h we=%b be=%b wdata=%h, want addr=%h we=%b be=%b wdata=%h",
                     name, bus_if.bus_addr, bus_if.bus_we, bus_if.bus_be, bus_if.bus_wdata,
                     exp_addr, we, we ? exp_be(addr, size) : 4'b0000, exp_wdata(wdata, size));
          end
          if (waits >= 0 && valid_n == waits) begin
            bus_if.bus_ready = 1'b1;
            bus_if.bus_rdata = slave_mem[bus_if.bus_addr[11:2]];
            if (bus_if.bus_we) begin
              be_w = bus_if.bus_be;
              for (int k = 0; k < 4; k++)
                if (be_w[k]) slave_mem[bus_if.bus_addr[11:2]][8*k +: 8] = bus_if.bus_wdata[8*k +: 8];
            end
          end else begin
            bus_if.bus_ready = 1'b0;
            bus_if.bus_rdata = $urandom;
          end
          valid_n++;
        end else begin
          bus_if.bus_ready = 1'($urandom_range(0, 1));
          bus_if.bus_rdata = $urandom;
        end
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    checks++;
    if (!done || stall_n != exp_stall || valid_n != exp_valid) begin
      errors++;
      $display("FAIL %s timing: done=%0d stall_cycles=%0d valid_cycles=%0d, want done=1 stall_cycles=%0d valid_cycles=%0d",
               name, done, stall_n, valid_n, exp_stall, exp_valid);
    end
    checks++;
    if (core_fault !== (waits < 0) || (!we && core_rdata !== exp_rd) || bus_if.bus_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s result: fault=%b rdata=%h valid=%b, want fault=%b rdata=%h valid=0",
               name, core_fault, core_rdata, bus_if.bus_valid, waits < 0, exp_rd);
    end
    if (we && waits >= 0)
      for (int unsigned i = 0; i < (1 << size); i++) ref_mem[addr - BASE + i] = 8'(wdata >> (8 * i));
    bus_if.bus_ready = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0; core_req = 1'b1; core_we = 1'b0; core_addr = 32'h1000;
    core_wdata = '0; core_size = 2'd2; core_unsigned = 1'b0;
    bus_if.bus_ready = 1'b1; bus_if.bus_rdata = 32'hA5A5_A5A5;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (core_stall !== 1'b0 || core_fault !== 1'b0 || core_rdata !== 32'h0 ||
        bus_if.bus_valid !== 1'b0 || bus_if.bus_be !== 4'b0 || bus_if.bus_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset: stall=%b fault=%b rdata=%h valid=%b be=%b addr=%h, want all 0",
               core_stall, core_fault, core_rdata, bus_if.bus_valid, bus_if.bus_be, bus_if.bus_addr);
    end
    @(negedge clk);
    core_req = 1'b0; rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      checks++;
      if (core_stall !== 1'b0 || core_fault !== 1'b0 || bus_if.bus_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_ready_ignored: stall=%b fault=%b valid=%b, want 0 0 0",
                 core_stall, core_fault, bus_if.bus_valid);
      end
    end
    bus_if.bus_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_word;
    run_op("sw_1008", 1'b1, 32'h1008, 32'hDEAD_BEEF, 2'd2, 1'b0, 0);
    run_op("lw_1008", 1'b0, 32'h1008, 32'h0, 2'd2, 1'b0, 2);
  endtask

  task automatic test_load_byte;
    mem_set(0, 32'h80FF_0011);
    run_op("lb_1003", 1'b0, 32'h1003, 32'h0, 2'd0, 1'b0, 3);
    run_op("lbu_1003", 1'b0, 32'h1003, 32'h0, 2'd0, 1'b1, 3);
    run_op("lh_1002", 1'b0, 32'h1002, 32'h0, 2'd1, 1'b0, 1);
  endtask

  task automatic test_half;
    run_op("sh_1006", 1'b1, 32'h1006, 32'h0000_1234, 2'd1, 1'b0, 0);
    run_op("lhu_1006", 1'b0, 32'h1006, 32'h0, 2'd1, 1'b1, 0);
    run_op("lh_1005_misaligned", 1'b0, 32'h1005, 32'h0, 2'd1, 1'b0, 0);
    run_op("sw_1002_misaligned", 1'b1, 32'h1002, 32'h1, 2'd2, 1'b0, 0);
    run_op("size_11", 1'b0, 32'h1000, 32'h0, 2'd3, 1'b0, 0);
  endtask

  task automatic test_out_of_range;
    run_op("lw_0ffc", 1'b0, 32'h0FFC, 32'h0, 2'd2, 1'b0, 0);
    run_op("lw_2000", 1'b0, 32'h2000, 32'h0, 2'd2, 1'b0, 0);
    run_op("lw_1ffc", 1'b0, 32'h1FFC, 32'h0, 2'd2, 1'b0, 0);
    run_op("lb_1fff", 1'b0, 32'h1FFF, 32'h0, 2'd0, 1'b0, 1);
  endtask

  task automatic test_timeout;
    run_op("lw_timeout", 1'b0, 32'h1000, 32'h0, 2'd2, 1'b0, -1);
    run_op("lw_after_timeout", 1'b0, 32'h1004, 32'h0, 2'd2, 1'b0, 0);
    run_op("lw_ready_at_limit", 1'b0, 32'h1010, 32'h0, 2'd2, 1'b0, TIMEOUT - 1);
  endtask

  task automatic test_reset_mid_bus;
    core_req = 1'b1; core_we = 1'b0; core_addr = 32'h1000; core_size = 2'd2; core_unsigned = 1'b0;
    bus_if.bus_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (bus_if.bus_valid !== 1'b1 || core_stall !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: valid=%b stall=%b, want 1 1", bus_if.bus_valid, core_stall);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus_if.bus_valid !== 1'b0 || core_stall !== 1'b0 || core_fault !== 1'b0) begin
      errors++;
      $display("FAIL midreset_drop: valid=%b stall=%b fault=%b, want 0 0 0",
               bus_if.bus_valid, core_stall, core_fault);
    end
    @(negedge clk);
    core_req = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    run_op("lw_after_reset", 1'b0, 32'h1000, 32'h0, 2'd2, 1'b0, 1);
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    logic [1:0]  sz;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'h0FF0 + $urandom_range(0, 15);
        1:       a = 32'h1FF8 + $urandom_range(0, 15);
        2:       a = $urandom;
        default: a = BASE + $urandom_range(0, SIZE - 1);
      endcase
      sz = 2'($urandom_range(0, 3));
      if (sz == 2'd1 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
      if (sz == 2'd2 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_op("random", 1'($urandom_range(0, 1)), a, $urandom, sz,
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    for (int unsigned i = 0; i < 1024; i++) mem_set(i, $urandom);
    test_reset();
    test_store_word();
    test_load_byte();
    test_half();
    test_out_of_range();
    test_timeout();
    test_reset_mid_bus();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

endmodule
